// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : key-mode encoding, Rcon table and per-mode Nk/Nr lookups
// Revision : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

   typedef enum logic [1:0] {
      KM_AES128  = 2'b00,
      KM_AES192  = 2'b01,
      KM_AES256  = 2'b10,
      KM_INVALID = 2'b11
   } key_mode_e;

   localparam logic [3:0] NK_AES128 = 4'd4;
   localparam logic [3:0] NK_AES192 = 4'd6;
   localparam logic [3:0] NK_AES256 = 4'd8;
   localparam logic [3:0] NR_AES128 = 4'd10;
   localparam logic [3:0] NR_AES192 = 4'd12;
   localparam logic [3:0] NR_AES256 = 4'd14;

   function automatic logic [3:0] mode_nk(input key_mode_e m);
      case (m)
         KM_AES192: return NK_AES192;
         KM_AES256: return NK_AES256;
         default:   return NK_AES128;
      endcase
   endfunction

   function automatic logic [3:0] mode_nr(input key_mode_e m);
      case (m)
         KM_AES192: return NR_AES192;
         KM_AES256: return NR_AES256;
         default:   return NR_AES128;
      endcase
   endfunction

   // Index 0 holds Rcon(1)
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : AES forward S-box, 8-bit combinational lookup
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the MSBs, so offset is (255 - i) * 8
   logic [10:0] w_off;
   assign w_off  = {~i_byte, 3'b000};
   assign o_byte = SBOX_TBL[w_off +: 8];

endmodule

`default_nettype wire

// File: rtl/aes_key_schedule.sv
// ============================================================================
// aes_key_schedule : iterative AES-128/192/256 key expansion, one word/clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int MAX_NK = 8,
   parameter int MAX_NR = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            key_mode,
   input  logic [MAX_NK*32-1:0]  key_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  rk_valid,
   input  logic [3:0]            rk_idx,
   output logic [127:0]          rk_out
);

   localparam int WORDS = 4 * (MAX_NR + 1);
   localparam int IW    = $clog2(WORDS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GEN  = 1'b1;

   logic [0:0]    r_state;
   logic [IW-1:0] r_i;
   logic [3:0]    r_nk;
   logic [3:0]    r_nr;
   logic [3:0]    r_mod;
   logic [3:0]    r_rc;
   logic          r_done;
   logic          r_err;
   logic          r_valid;
   logic [127:0]  r_rk;
   logic [31:0]   r_w [0:WORDS-1];

   key_mode_e     w_mode;
   logic [3:0]    w_mode_nk;
   logic          w_load;
   logic          w_gen;
   logic [IW-1:0] w_last;
   logic [31:0]   w_prev;
   logic [31:0]   w_back;
   logic [31:0]   w_sub_in;
   logic [31:0]   w_sub;
   logic [31:0]   w_temp;
   logic [31:0]   w_new;
   logic [IW-1:0] w_base;

   assign w_mode    = key_mode_e'(key_mode);
   assign w_mode_nk = mode_nk(w_mode);
   assign w_load    = (r_state == ST_IDLE) && start && (w_mode != KM_INVALID);
   assign w_gen     = (r_state == ST_GEN);
   assign w_last    = IW'({r_nr, 2'b11});

   assign w_prev    = r_w[r_i - IW'(1)];
   assign w_back    = r_w[r_i - IW'(r_nk)];
   assign w_sub_in  = (r_mod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte (w_sub_in[8*b +: 8]),
         .o_byte (w_sub[8*b +: 8])
      );
   end

   always_comb begin
      w_temp = w_prev;
      if (r_mod == 4'd0) begin
         w_temp = w_sub ^ {rcon(r_rc), 24'h000000};
      end else if ((r_nk == NK_AES256) && (r_mod == 4'd4)) begin
         w_temp = w_sub;
      end
   end

   assign w_new = w_back ^ w_temp;

   // Storage is deliberately unreset: rk_valid gates every read
   always_ff @(posedge clk) begin
      if (w_load) begin
         for (int j = 0; j < MAX_NK; j++) begin
            if (j < int'(w_mode_nk)) begin
               r_w[IW'(j)] <= key_in[MAX_NK*32-1-32*j -: 32];
            end
         end
      end else if (w_gen) begin
         r_w[r_i] <= w_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_i     <= '0;
         r_nk    <= NK_AES128;
         r_nr    <= NR_AES128;
         r_mod   <= '0;
         r_rc    <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && (w_mode == KM_INVALID)) begin
                  r_err <= 1'b1;
               end else if (start) begin
                  r_state <= ST_GEN;
                  r_nk    <= w_mode_nk;
                  r_nr    <= mode_nr(w_mode);
                  r_i     <= IW'(w_mode_nk);
                  r_mod   <= '0;
                  r_rc    <= '0;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_i   <= r_i + IW'(1);
               r_mod <= (r_mod == r_nk - 4'd1) ? 4'd0 : r_mod + 4'd1;
               if (r_mod == 4'd0) begin
                  r_rc <= r_rc + 4'd1;
               end
               if (r_i == w_last) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                  r_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   assign w_base = IW'({rk_idx, 2'b00});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rk <= '0;
      end else if (r_valid && (rk_idx <= r_nr)) begin
         r_rk <= {r_w[w_base], r_w[w_base + IW'(1)],
                  r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]};
      end else begin
         r_rk <= '0;
      end
   end

   assign busy     = (r_state == ST_GEN);
   assign done     = r_done;
   assign err      = r_err;
   assign rk_valid = r_valid;
   assign rk_out   = r_rk;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
// ============================================================================
// tb_aes_key_schedule : known-answer, random-key and control-path scenarios
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   key_mode;
   logic [255:0] key_in;
   logic         busy, done, err, rk_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   int vecs = 0;
   int errs = 0;

   logic [7:0]  m_sbox [0:255];
   logic [31:0] m_w    [0:59];

   localparam logic [255:0] KAT_K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KAT_K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KAT_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] KAT_R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   always #5 clk = ~clk;

   aes_key_schedule #(.MAX_NK(8), .MAX_NR(14)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_mode (key_mode),
      .key_in   (key_in),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rk_valid (rk_valid),
      .rk_idx   (rk_idx),
      .rk_out   (rk_out)
   );

   // ---------------- reference model: GF(2^8) arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256 && a != 0; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
   endfunction

   task automatic model_expand(input logic [255:0] key, input int mode);
      int nk, nr;
      logic [31:0] t;
      logic [7:0]  rc;
      nk = 4 + 2 * mode;
      nr = nk + 6;
      for (int j = 0; j < nk; j++) m_w[j] = key[255-32*j -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = m_w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         m_w[i] = m_w[i-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] model_rk(input int r, input int mode);
      if (r > 10 + 2 * mode) return '0;
      return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] mode, input logic [255:0] key);
      key_mode = mode;
      key_in   = key;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(inout int lat);
      do begin
         tick();
         lat++;
      end while (done !== 1'b1 && lat < 200);
   endtask

   task automatic read_rk(input int idx, output logic [127:0] v);
      rk_idx = 4'(idx);
      tick();
      v = rk_out;
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
      return k;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      tick();
      rst = 1'b1;
      #2;
      vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
      vecs++; if (done !== 1'b0)     begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
      vecs++; if (err !== 1'b0)      begin errs++; $display("FAIL reset_err got=%b exp=0", err); end
      vecs++; if (rk_valid !== 1'b0) begin errs++; $display("FAIL reset_rk_valid got=%b exp=0", rk_valid); end
      vecs++; if (rk_out !== 128'h0) begin errs++; $display("FAIL reset_rk_out got=%h exp=0", rk_out); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_kat();
      logic [255:0] keys [3];
      int           lats [3];
      int           ia   [3];
      int           ib   [3];
      logic [127:0] ea   [3];
      logic [127:0] eb   [3];
      logic [127:0] v;
      int           lat;
      keys = '{KAT_K128, KAT_K192, KAT_K256};
      lats = '{40, 46, 52};
      ia   = '{10, 12, 14};
      ea   = '{KAT_R128, 128'he98ba06f448c773c8ecc720401002202,
               128'hfe4890d1e6188d0b046df344706c631e};
      ib   = '{11, 13, 0};
      eb   = '{128'h0, 128'h0, 128'h603deb1015ca71be2b73aef0857d7781};
      for (int m = 0; m < 3; m++) begin
         start_run(2'(m), keys[m]);
         vecs++; if (busy !== 1'b1 || rk_valid !== 1'b0) begin errs++; $display("FAIL kat_busy mode=%0d got busy=%b valid=%b exp 1/0", m, busy, rk_valid); end
         lat = 0;
         wait_done(lat);
         vecs++; if (lat != lats[m]) begin errs++; $display("FAIL kat_latency mode=%0d got=%0d exp=%0d", m, lat, lats[m]); end
         vecs++; if (busy !== 1'b0 || rk_valid !== 1'b1) begin errs++; $display("FAIL kat_complete mode=%0d got busy=%b valid=%b exp 0/1", m, busy, rk_valid); end
         read_rk(ia[m], v);
         vecs++; if (done !== 1'b0) begin errs++; $display("FAIL kat_done_width mode=%0d got=%b exp=0", m, done); end
         vecs++; if (v !== ea[m]) begin errs++; $display("FAIL kat_rk mode=%0d idx=%0d got=%h exp=%h", m, ia[m], v, ea[m]); end
         read_rk(ib[m], v);
         vecs++; if (v !== eb[m]) begin errs++; $display("FAIL kat_rk mode=%0d idx=%0d got=%h exp=%h", m, ib[m], v, eb[m]); end
      end
   endtask

   task automatic test_random();
      logic [255:0] k;
      logic [127:0] v;
      int           lat;
      for (int n = 0; n < 6; n++) begin
         int m = n % 3;
         k = rand_key();
         model_expand(k, m);
         start_run(2'(m), k);
         lat = 0;
         wait_done(lat);
         vecs++; if (lat != 40 + 6 * m) begin errs++; $display("FAIL rand_latency mode=%0d got=%0d exp=%0d", m, lat, 40 + 6 * m); end
         for (int r = 0; r < 16; r++) begin
            read_rk(r, v);
            vecs++; if (v !== model_rk(r, m)) begin errs++; $display("FAIL rand_rk mode=%0d idx=%0d got=%h exp=%h", m, r, v, model_rk(r, m)); end
         end
      end
   endtask

   task automatic test_invalid();
      logic [127:0] v;
      int           lat = 0;
      start_run(2'd0, KAT_K128);
      wait_done(lat);
      start_run(2'b11, rand_key());
      vecs++; if (err !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL invalid_err got err=%b busy=%b exp 1/0", err, busy); end
      tick();
      vecs++; if (err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL invalid_pulse got err=%b busy=%b exp 0/0", err, busy); end
      vecs++; if (rk_valid !== 1'b1) begin errs++; $display("FAIL invalid_valid got=%b exp=1", rk_valid); end
      read_rk(10, v);
      vecs++; if (v !== KAT_R128) begin errs++; $display("FAIL invalid_rk got=%h exp=%h", v, KAT_R128); end
   endtask

   task automatic test_back_to_back();
      logic [255:0] k1;
      logic [127:0] v;
      int           lat;
      k1 = rand_key();
      model_expand(k1, 0);
      start_run(2'd0, k1);
      rk_idx = 4'd0;
      lat = 0;
      for (int c = 0; c < 9; c++) begin
         tick();
         lat++;
      end
      vecs++; if (rk_out !== 128'h0 || rk_valid !== 1'b0) begin errs++; $display("FAIL gen_read got=%h valid=%b exp 0/0", rk_out, rk_valid); end
      key_mode = 2'd2;
      key_in   = rand_key();
      start    = 1'b1;
      tick();
      lat++;
      start    = 1'b0;
      vecs++; if (err !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL busy_start got err=%b busy=%b exp 0/1", err, busy); end
      wait_done(lat);
      vecs++; if (lat != 40) begin errs++; $display("FAIL busy_start_latency got=%0d exp=40", lat); end
      for (int r = 0; r < 16; r++) begin
         read_rk(r, v);
         vecs++; if (v !== model_rk(r, 0)) begin errs++; $display("FAIL busy_start_rk idx=%0d got=%h exp=%h", r, v, model_rk(r, 0)); end
      end
   endtask

   task automatic test_done_coincident();
      logic [255:0] k1;
      logic [127:0] v;
      k1 = rand_key();
      model_expand(k1, 1);
      start_run(2'd1, k1);
      for (int c = 0; c < 45; c++) tick();
      key_mode = 2'd0;
      key_in   = rand_key();
      start    = 1'b1;
      tick();
      start    = 1'b0;
      vecs++; if (done !== 1'b1) begin errs++; $display("FAIL coincide_done got=%b exp=1", done); end
      tick();
      vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL coincide_idle got busy=%b done=%b exp 0/0", busy, done); end
      for (int r = 0; r < 14; r++) begin
         read_rk(r, v);
         vecs++; if (v !== model_rk(r, 1)) begin errs++; $display("FAIL coincide_rk idx=%0d got=%h exp=%h", r, v, model_rk(r, 1)); end
      end
   endtask

   task automatic test_abort_reset();
      logic [127:0] v;
      int           seen_done = 0;
      int           lat = 0;
      start_run(2'd2, KAT_K256);
      for (int c = 1; c < 30; c++) begin
         if (c == 20) begin
            key_mode = 2'd2;
            key_in   = rand_key();
            start    = 1'b1;
         end
         tick();
         start = 1'b0;
         if (done === 1'b1) seen_done++;
      end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_busy got=%b exp=1", busy); end
      #2;
      rst = 1'b1;
      #1;
      vecs++; if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== 128'h0) begin errs++; $display("FAIL abort_reset got busy=%b valid=%b rk=%h exp 0/0/0", busy, rk_valid, rk_out); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (done === 1'b1) seen_done++;
      end
      vecs++; if (seen_done != 0) begin errs++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
      read_rk(0, v);
      vecs++; if (v !== 128'h0 || rk_valid !== 1'b0) begin errs++; $display("FAIL abort_read got=%h valid=%b exp 0/0", v, rk_valid); end
      start_run(2'd0, KAT_K128);
      wait_done(lat);
      vecs++; if (lat != 40) begin errs++; $display("FAIL abort_rerun_latency got=%0d exp=40", lat); end
      read_rk(10, v);
      vecs++; if (v !== KAT_R128) begin errs++; $display("FAIL abort_rerun_rk got=%h exp=%h", v, KAT_R128); end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      key_mode = 2'd0;
      key_in   = '0;
      rk_idx   = 4'd0;
      build_sbox();
      test_reset();
      test_kat();
      test_random();
      test_invalid();
      test_back_to_back();
      test_done_coincident();
      test_abort_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have parameter MAX_NK, default 8, giving the largest supported key length in 32-bit words.
REQ-002 The block SHALL have parameter MAX_NR, default 14, giving the largest supported round count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to expand key_in, sampled on the rising clk edge.
REQ-006 The block SHALL have port key_mode, input, 2 bits: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = invalid.
REQ-007 The block SHALL have port key_in, input, MAX_NK*32 bits: the cipher key, left-justified; the low unused words are ignored for Nk<8.
REQ-008 The block SHALL have port busy, output, 1 bit: an expansion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the schedule is complete.
REQ-010 The block SHALL have port err, output, 1 bit: a one-cycle pulse when start arrives with key_mode=11.
REQ-011 The block SHALL have port rk_valid, output, 1 bit: the stored schedule is complete and consistent.
REQ-012 The block SHALL have port rk_idx, input, 4 bits: the round-key index for the read port.
REQ-013 The block SHALL have port rk_out, output, 128 bits: the registered round key rk_idx, returned as words w[4r..4r+3] with w[4r] in the MSBs.

Function
REQ-014 A start while idle with a valid mode SHALL latch key_mode and write key words w[0..Nk-1] at that edge, enter state GEN, set busy=1 and clear rk_valid.
REQ-015 In GEN the block SHALL compute one word w[i] per clock for i=Nk..4(Nr+1)-1, where w[i] = w[i-Nk] ^ temp.
REQ-016 temp SHALL equal SubWord(RotWord(w[i-1])) ^ Rcon(i/Nk) when i mod Nk = 0.
REQ-017 temp SHALL equal SubWord(w[i-1]) when Nk=8 and i mod Nk = 4.
REQ-018 In all other cases temp SHALL equal w[i-1].
REQ-019 Rcon(j) SHALL use the sequence 01,02,04,08,10,20,40,80,1b,36 in the top byte, for j=1..10.
REQ-020 Generation latency SHALL be 40, 46 or 52 clock edges after the start edge for AES-128, AES-192 and AES-256 respectively.
REQ-021 At the edge that writes the final word the block SHALL return to IDLE, set busy=0 and rk_valid=1, and pulse done for exactly one cycle.
REQ-022 The state machine SHALL have states IDLE and GEN only; transitions are IDLE->GEN on a valid start and GEN->IDLE on the final word.
REQ-023 Start SHALL be ignored while busy=1, with no restart, no err pulse and the latched key unchanged.
REQ-024 Start with key_mode=11 SHALL pulse err for one cycle, leave state IDLE, and leave both the storage and rk_valid unchanged.
REQ-025 Word storage SHALL hold 4*(MAX_NR+1)=60 words of 32 bits.
REQ-026 rk_out SHALL update one cycle after rk_idx is sampled.
REQ-027 rk_out SHALL be all-zero when rk_idx exceeds the latched Nr or when rk_valid=0.
REQ-028 Reads SHALL be permitted during GEN and SHALL return zero, because rk_valid=0.
REQ-029 A start that coincides with the done edge SHALL be treated as arriving while busy and ignored; the next cycle is IDLE.

Reset
REQ-030 While rst=1, regardless of clk, the block SHALL force state=IDLE, busy=0, done=0, err=0, rk_valid=0, rk_out=0 and the word index to 0.
REQ-031 Reset asserted mid-GEN SHALL abort the expansion with no done pulse; storage contents are don't-care because rk_valid=0 gates all reads.
REQ-032 The first start after reset release SHALL behave exactly per REQ-014.

Structure
REQ-033 Shared package aes_pkg SHALL hold the key_mode encoding enum, the Rcon table, and the Nk/Nr lookup constants per mode.
REQ-034 Byte substitution SHALL be a sub-module aes_sbox (8-bit combinational lookup), with four instances for SubWord; no other sub-modules.

Verification
REQ-035 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done 40 edges later; rk_idx=10 gives rk_out d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-036 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done 46 edges later; rk_idx=12 gives e98ba06f448c773c8ecc720401002202; rk_idx=13 gives 0.
REQ-037 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done 52 edges later; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e; rk_idx=0 gives 603deb1015ca71be2b73aef0857d7781.
REQ-038 Start with key_mode=11 after a valid AES-128 run -> err pulses once, busy stays 0, rk_idx=10 still gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 AES-256 start, second start with a different key at cycle 20, rst at cycle 30 -> second start ignored, no done, rk_valid=0, rk_out=0; a fresh AES-128 run then completes per REQ-035.
